// File: rtl/bw_io_ddr_imp_pkg.sv
// Shared definitions for the DDR impedance-code serializer and the pad-slice
// deserializer model: FSM state encoding, default code width and frame length.
package bw_io_ddr_imp_pkg;
  localparam int CODE_W_DEF = 8;

  // One serial frame carries the pull-up code followed by the pull-down code.
  function automatic int frame_len(input int cw);
    return 2 * cw;
  endfunction

  localparam int FRAME_W = frame_len(CODE_W_DEF);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, HOLD} state_e;
endpackage

// File: rtl/bw_io_ddr_imp_piso.sv
// Generic parallel-in serial-out register with bit counter.
//   clk, rst_n : clock, async active-low reset
//   load, din  : parallel load (also clears the bit counter)
//   shift      : shift left one bit, zero fill, count one bit
//   sout       : current MSB (bit on the wire)
//   done       : asserted on the shift cycle that moves the last bit out
module bw_io_ddr_imp_piso #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout,
  output logic         done
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
    end else if (shift) begin
      // zero fill leaves the register empty once a frame has gone out,
      // so sout idles low without extra gating
      sr  <= {sr[W-2:0], 1'b0};
      cnt <= cnt + 1'b1;
    end
  end

  assign sout = sr[W-1];
  assign done = shift && (cnt == CW'(W - 1));
endmodule

// File: rtl/bw_io_ddr_imp_code_shftr.sv
// DDR impedance-code shifter. Accepts a pull-up/pull-down code pair from
// calibration, streams it serially (pu MSB first, then pd MSB first) down the
// repeater chain, then pulses upd while the DRAM bus is idle so the pads load
// the new drive strength atomically.
//   clk, arst_l        : clock, async active-low reset
//   code_vld/code_rdy  : code handshake (rdy only in IDLE)
//   code_pu, code_pd   : impedance codes
//   dram_idle          : update window open (sampled only in LATCH)
//   sdo, sen           : serial data and shift qualifier to repeaters
//   upd                : one-cycle latch pulse to pads
//   busy               : FSM not in IDLE
module bw_io_ddr_imp_code_shftr
  import bw_io_ddr_imp_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              arst_l,
  input  logic              code_vld,
  input  logic [CODE_W-1:0] code_pu,
  input  logic [CODE_W-1:0] code_pd,
  output logic              code_rdy,
  input  logic              dram_idle,
  output logic              sdo,
  output logic              sen,
  output logic              upd,
  output logic              busy
);
  localparam int FW = frame_len(CODE_W);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_e        state;
  logic [FW-1:0] code_cat, pend_q, last_q;
  logic          applied_vld;
  logic [HW-1:0] hcnt;
  logic          sen_q, busy_q;
  logic          xfer, dup, load, shift, frame_done;

  assign code_cat = {code_pu, code_pd};
  assign code_rdy = (state == IDLE);
  assign xfer     = code_vld && code_rdy;
  // a code identical to the one already in the pads is consumed silently
  assign dup      = applied_vld && (code_cat == last_q);
  assign load     = xfer && !dup;
  assign shift    = (state == SHIFT);
  assign upd      = (state == LATCH) && dram_idle;
  assign sen      = sen_q;
  assign busy     = busy_q;

  bw_io_ddr_imp_piso #(.W(FW)) u_piso (
    .clk   (clk),
    .rst_n (arst_l),
    .load  (load),
    .shift (shift),
    .din   (code_cat),
    .sout  (sdo),
    .done  (frame_done)
  );

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state       <= IDLE;
      pend_q      <= '0;
      last_q      <= '0;
      applied_vld <= 1'b0;
      hcnt        <= '0;
      sen_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          pend_q <= code_cat;
          sen_q  <= 1'b1;
          busy_q <= 1'b1;
          state  <= SHIFT;
        end
        SHIFT: if (frame_done) begin
          sen_q <= 1'b0;
          state <= LATCH;
        end
        // shifted code waits in the pads until the bus goes idle
        LATCH: if (dram_idle) begin
          last_q      <= pend_q;
          applied_vld <= 1'b1;
          hcnt        <= '0;
          state       <= HOLD;
        end
        HOLD: begin
          if (hcnt == HW'(HOLD_CYC - 1)) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
